// File: rtl/count_seq_pkg.sv
// count_seq_pkg: state encoding, rate-select codes and the divider reload helper
// shared by count_sequencer and its bench.
package count_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        HOLD = 3'd3,
        DONE = 3'd4
    } state_e;

    localparam logic [1:0] RATE_EVERY      = 2'b00;
    localparam logic [1:0] RATE_1HZ        = 2'b01;
    localparam logic [1:0] RATE_HALF_HZ    = 2'b10;
    localparam logic [1:0] RATE_QUARTER_HZ = 2'b11;

    // Strobe period in clocks, minus one: 1, CLK_HZ, 2*CLK_HZ or 4*CLK_HZ.
    function automatic logic [31:0] rate_reload(input logic [1:0] rate, input int unsigned clk_hz);
        logic [31:0] period;
        case (rate)
            RATE_EVERY:      period = 32'd1;
            RATE_1HZ:        period = clk_hz;
            RATE_HALF_HZ:    period = clk_hz << 1;
            RATE_QUARTER_HZ: period = clk_hz << 2;
            default:         period = 32'd1;
        endcase
        return period - 32'd1;
    endfunction

endpackage

// File: rtl/count_sequencer_rate_divider.sv
// rate_divider: DIV_W-bit down-counter with load and hold; tick_o flags div==0.
// The owner reloads on tick, so it never underflows while running.
module rate_divider #(
    parameter int DIV_W = 28
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_val_i,
    input  logic             hold_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        div_d = div_q;
        if (load_i) begin
            div_d = load_val_i;
        end else if (!hold_i) begin
            div_d = div_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick_o = (div_q == '0);

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: run controller for the 8-bit counter (enable strobes, clear, limit stop).
// Optional build macro AUTO_RELOAD_EN: DONE is a one-cycle pulse that reloads straight into LOAD.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int WIDTH  = 8,
    parameter int DIV_W  = 28
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       rate_sel,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] count_in,
    output logic             cnt_en,
    output logic             cnt_clear_b,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    state_e           state_d;
    logic             cnt_en_q;
    logic             cnt_en_d;
    logic             cnt_clear_b_q;
    logic             busy_q;
    logic             done_q;
    logic             div_load;
    logic             div_hold;
    logic             div_tick;
    logic             run_go;
    logic             at_limit;
    logic [WIDTH:0]   eff_count;
    logic [DIV_W-1:0] reload_val;

    assign reload_val = DIV_W'(rate_reload(rate_sel, CLK_HZ));

    // A strobe showing on cnt_en has not reached count_in yet; count it so the
    // compare never lets one more strobe through. The extra bit keeps 255+1 from wrapping.
    assign eff_count = {1'b0, count_in} + {{WIDTH{1'b0}}, cnt_en_q};
    assign at_limit  = (eff_count == {1'b0, limit});

    assign run_go   = (state_q == RUN) && !stop && !at_limit;
    assign div_load = (state_q == LOAD) || (run_go && div_tick);
    assign div_hold = !run_go;

    rate_divider #(
        .DIV_W(DIV_W)
    ) u_div (
        .clock     (clock),
        .clear     (clear),
        .load_i    (div_load),
        .load_val_i(reload_val),
        .hold_i    (div_hold),
        .tick_o    (div_tick)
    );

    always_comb begin
        state_d  = state_q;
        cnt_en_d = 1'b0;
        case (state_q)
            IDLE: if (start && !stop) state_d = LOAD;
            LOAD: state_d = RUN;
            RUN: begin
                if (stop) begin
                    state_d = HOLD;
                end else if (at_limit) begin
                    state_d = DONE;
                end else if (div_tick) begin
                    cnt_en_d = 1'b1;
                end
            end
            HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            DONE: begin
`ifdef AUTO_RELOAD_EN
                state_d = stop ? IDLE : LOAD;
`else
                if (start && !stop) state_d = LOAD;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they line up with the state they describe.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q       <= IDLE;
            cnt_en_q      <= 1'b0;
            cnt_clear_b_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_en_q      <= cnt_en_d;
            cnt_clear_b_q <= (state_d != LOAD);
            busy_q        <= (state_d == LOAD) || (state_d == RUN) || (state_d == HOLD);
            done_q        <= (state_d == DONE);
        end
    end

    assign cnt_en      = cnt_en_q;
    assign cnt_clear_b = cnt_clear_b_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed bench for count_sequencer with CLK_HZ=4 and a behavioural
// counter_logic (sync active-low clear, +1 on enable) closing the count_in loop.
module tb_count_sequencer;

    localparam int CLK_HZ = 4;
    localparam int WIDTH  = 8;
    localparam int DIV_W  = 28;

    logic             clock = 1'b0;
    logic             clear = 1'b1;
    logic             start = 1'b0;
    logic             stop  = 1'b0;
    logic [1:0]       rate_sel = 2'b00;
    logic [WIDTH-1:0] limit = '0;
    logic [WIDTH-1:0] count_q;
    logic             cnt_en;
    logic             cnt_clear_b;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    // counter_logic stand-in
    always @(posedge clock) begin
        if (cnt_clear_b === 1'b0) begin
            count_q <= '0;
        end else if (cnt_en === 1'b1) begin
            count_q <= count_q + 8'd1;
        end
    end

    count_sequencer #(
        .CLK_HZ(CLK_HZ),
        .WIDTH (WIDTH),
        .DIV_W (DIV_W)
    ) dut (
        .clock      (clock),
        .clear      (clear),
        .start      (start),
        .stop       (stop),
        .rate_sel   (rate_sel),
        .limit      (limit),
        .count_in   (count_q),
        .cnt_en     (cnt_en),
        .cnt_clear_b(cnt_clear_b),
        .busy       (busy),
        .done       (done)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Clear, program rate/limit, pulse start; returns in the first RUN cycle (R0).
    task automatic start_run(input logic [1:0] r, input logic [7:0] lim);
        clear = 1'b1;
        step();
        clear = 1'b0;
        rate_sel = r;
        limit = lim;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic test_reset();
        clear = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        step();
        step();
        total++; if (cnt_en !== 1'b0) begin bad++; $display("FAIL reset_cnt_en: got %b want 0", cnt_en); end
        total++; if (cnt_clear_b !== 1'b0) begin bad++; $display("FAIL reset_clear_b: got %b want 0", cnt_clear_b); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (count_q !== 8'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count_q); end
        clear = 1'b0;
        step();
        total++; if (cnt_clear_b !== 1'b1) begin bad++; $display("FAIL idle_clear_b: got %b want 1", cnt_clear_b); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL idle_flags: got busy=%b done=%b want 0/0", busy, done); end
    endtask

    task automatic test_rate_every();
        int n = 0;
        int first = -1;
        int last = -1;
        int done_at = -1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        rate_sel = 2'b00;
        limit = 8'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (cnt_clear_b !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL load_cycle: got clear_b=%b busy=%b want 0/1", cnt_clear_b, busy); end
        step();
        total++; if (cnt_clear_b !== 1'b1 || cnt_en !== 1'b0) begin bad++; $display("FAIL run_entry: got clear_b=%b en=%b want 1/0", cnt_clear_b, cnt_en); end
        for (int i = 1; i <= 20; i++) begin
            step();
            if (cnt_en === 1'b1) begin
                n++;
                if (first < 0) first = i;
                last = i;
            end
            if (done === 1'b1) begin
                done_at = i;
                break;
            end
        end
        total++; if (n != 5) begin bad++; $display("FAIL every_strobes: got %0d want 5", n); end
        total++; if (first != 1 || last != 5) begin bad++; $display("FAIL every_span: got %0d..%0d want 1..5", first, last); end
        total++; if (done_at != 6) begin bad++; $display("FAIL every_done_at: got %0d want 6", done_at); end
        total++; if (count_q !== 8'd5) begin bad++; $display("FAIL every_count: got %0d want 5", count_q); end
    endtask

    // The div==0 decision lands on cnt_en one cycle later: first strobe one full period after R0.
    task automatic test_rate_slow(input logic [1:0] r, input logic [7:0] lim, input int period, input int exp_done_at);
        int n = 0;
        int done_at = -1;
        int t[4];
        start_run(r, lim);
        for (int i = 1; i <= 80; i++) begin
            step();
            if (cnt_en === 1'b1) begin
                if (n < 4) t[n] = i;
                n++;
            end
            if (done === 1'b1) begin
                done_at = i;
                break;
            end
        end
        total++; if (n != int'(lim)) begin bad++; $display("FAIL slow_strobes r=%0d: got %0d want %0d", r, n, lim); end
        for (int k = 0; k < int'(lim) && k < n && k < 4; k++) begin
            total++; if (t[k] != period * (k + 1)) begin bad++; $display("FAIL slow_time r=%0d k=%0d: got %0d want %0d", r, k, t[k], period * (k + 1)); end
        end
        total++; if (done_at != exp_done_at) begin bad++; $display("FAIL slow_done_at r=%0d: got %0d want %0d", r, done_at, exp_done_at); end
        total++; if (count_q !== lim) begin bad++; $display("FAIL slow_count r=%0d: got %0d want %0d", r, count_q, lim); end
    endtask

    task automatic test_hold();
        int n = 0;
        int nh = 0;
        int done_at = -1;
        int tk[2];
        start_run(2'b01, 8'd4);
        for (int i = 1; i <= 8; i++) begin
            step();
            if (cnt_en === 1'b1) n++;
        end
        total++; if (n != 2 || cnt_en !== 1'b1) begin bad++; $display("FAIL hold_pre: got n=%0d en=%b want 2/1", n, cnt_en); end
        stop = 1'b1;
        step();
        stop = 1'b0;
        total++; if (busy !== 1'b1 || cnt_en !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL hold_enter: got busy=%b en=%b done=%b want 1/0/0", busy, cnt_en, done); end
        for (int i = 0; i < 6; i++) begin
            step();
            if (cnt_en === 1'b1) nh++;
        end
        total++; if (nh != 0 || count_q !== 8'd2) begin bad++; $display("FAIL hold_quiet: got strobes=%0d count=%0d want 0/2", nh, count_q); end
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (cnt_en === 1'b1) begin
                if (n < 2) tk[n] = k;
                n++;
            end
            if (done === 1'b1) begin
                done_at = k;
                break;
            end
        end
        // Divider was frozen at 3 when stop was seen, so four more cycles to the next strobe.
        total++; if (n != 2) begin bad++; $display("FAIL resume_strobes: got %0d want 2", n); end
        total++; if (n >= 2 && (tk[0] != 4 || tk[1] != 8)) begin bad++; $display("FAIL resume_time: got %0d,%0d want 4,8", tk[0], tk[1]); end
        total++; if (done_at != 9 || count_q !== 8'd4) begin bad++; $display("FAIL resume_done: got at=%0d count=%0d want 9/4", done_at, count_q); end

        start_run(2'b01, 8'd4);
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        total++; if (busy !== 1'b1 || done !== 1'b0 || cnt_en !== 1'b0) begin bad++; $display("FAIL startstop_hold: got busy=%b done=%b en=%b want 1/0/0", busy, done, cnt_en); end
        nh = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (cnt_en === 1'b1) nh++;
        end
        total++; if (nh != 0 || count_q !== 8'd0) begin bad++; $display("FAIL startstop_quiet: got strobes=%0d count=%0d want 0/0", nh, count_q); end
        stop = 1'b1;
        step();
        stop = 1'b0;
        total++; if (busy !== 1'b0 || cnt_clear_b !== 1'b1) begin bad++; $display("FAIL hold_to_idle: got busy=%b clear_b=%b want 0/1", busy, cnt_clear_b); end
    endtask

    task automatic test_limit_zero_and_clear();
        int n = 0;
        start_run(2'b00, 8'd0);
        total++; if (cnt_en !== 1'b0) begin bad++; $display("FAIL lim0_r0_en: got %b want 0", cnt_en); end
        step();
        total++; if (done !== 1'b1 || cnt_en !== 1'b0) begin bad++; $display("FAIL lim0_done: got done=%b en=%b want 1/0", done, cnt_en); end
        for (int i = 0; i < 8; i++) begin
            step();
            if (cnt_en === 1'b1) n++;
        end
        total++; if (n != 0 || count_q !== 8'd0) begin bad++; $display("FAIL lim0_quiet: got strobes=%0d count=%0d want 0/0", n, count_q); end

        start_run(2'b00, 8'd200);
        for (int i = 0; i < 10; i++) step();
        total++; if (count_q !== 8'd9 || cnt_en !== 1'b1) begin bad++; $display("FAIL midrun_count: got count=%0d en=%b want 9/1", count_q, cnt_en); end
        clear = 1'b1;
        step();
        clear = 1'b0;
        total++; if (busy !== 1'b0 || cnt_en !== 1'b0 || cnt_clear_b !== 1'b0) begin bad++; $display("FAIL midrun_clear: got busy=%b en=%b clear_b=%b want 0/0/0", busy, cnt_en, cnt_clear_b); end
        step();
        total++; if (count_q !== 8'd0 || cnt_clear_b !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL after_clear: got count=%0d clear_b=%b busy=%b want 0/1/0", count_q, cnt_clear_b, busy); end
    endtask

`ifdef AUTO_RELOAD_EN
    task automatic test_done_mode();
        logic [7:0] exp_en;
        logic [7:0] exp_done;
        logic [7:0] exp_clrb;
        exp_en   = 8'b0110_0011;
        exp_done = 8'b1000_0100;
        exp_clrb = 8'b1111_0111;
        start_run(2'b00, 8'd2);
        for (int i = 1; i <= 8; i++) begin
            step();
            total++;
            if ({cnt_en, done, cnt_clear_b} !== {exp_en[i-1], exp_done[i-1], exp_clrb[i-1]}) begin
                bad++;
                $display("FAIL auto_cycle%0d: got en/done/clr_b=%b%b%b want %b%b%b", i, cnt_en, done, cnt_clear_b, exp_en[i-1], exp_done[i-1], exp_clrb[i-1]);
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0 || cnt_clear_b !== 1'b1) begin bad++; $display("FAIL auto_stop: got busy=%b done=%b clear_b=%b want 0/0/1", busy, done, cnt_clear_b); end
        step();
        step();
        total++; if (busy !== 1'b0 || cnt_en !== 1'b0) begin bad++; $display("FAIL auto_idle: got busy=%b en=%b want 0/0", busy, cnt_en); end
    endtask
`else
    task automatic test_done_mode();
        int done_at = -1;
        int dh = 0;
        int ns = 0;
        start_run(2'b00, 8'd2);
        for (int i = 1; i <= 10; i++) begin
            step();
            if (done === 1'b1) begin
                done_at = i;
                break;
            end
        end
        total++; if (done_at != 3) begin bad++; $display("FAIL hold_done_at: got %0d want 3", done_at); end
        for (int i = 0; i < 20; i++) begin
            step();
            if (done === 1'b1) dh++;
            if (cnt_en === 1'b1) ns++;
        end
        total++; if (dh != 20 || ns != 0) begin bad++; $display("FAIL done_sticky: got done_cycles=%0d strobes=%0d want 20/0", dh, ns); end
        total++; if (count_q !== 8'd2) begin bad++; $display("FAIL done_count: got %0d want 2", count_q); end
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (cnt_clear_b !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL restart_load: got clear_b=%b done=%b busy=%b want 0/0/1", cnt_clear_b, done, busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_rate_every();
        test_rate_slow(2'b01, 8'd3, 4, 13);
        test_rate_slow(2'b11, 8'd2, 16, 33);
        test_hold();
        test_limit_zero_and_clear();
        test_done_mode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
